tlb: RTL and testbench

16-entry (parameterizable) fully-associative LoongArch TLB. It is the responder for the TLB write/read interface driven by the write-back stage, which issues TLBWR, TLBFILL and TLBRD. It also serves two combinational search ports: port 0 for instruction fetch, and port 1 for load/store and TLBSRCH. It stores entries in flops and applies INVTLB invalidations issued from the execute stage.

---
 rtl/tlb_pkg.sv | 48 ++++
 rtl/tlb_match.sv | 60 ++++++
 rtl/tlb.sv | 220 ++++++++++++++++++++++
 tb/tb_tlb.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared widths, page-pair payload, INVTLB op codes and page-size constants for the TLB.
package tlb_pkg;

  localparam int unsigned VPPN_W = 19;
  localparam int unsigned PPN_W  = 20;
  localparam int unsigned PS_W   = 6;
  localparam int unsigned ASID_W = 10;
  localparam int unsigned PLV_W  = 2;
  localparam int unsigned MAT_W  = 2;
  localparam int unsigned OP_W   = 5;

  // Supported page sizes (log2 of page bytes)
  localparam logic [PS_W-1:0] PS_4K = 6'd12;
  localparam logic [PS_W-1:0] PS_2M = 6'd21;

  // INVTLB operation codes
  localparam logic [OP_W-1:0] INVTLB_ALL0     = 5'd0;
  localparam logic [OP_W-1:0] INVTLB_ALL1     = 5'd1;
  localparam logic [OP_W-1:0] INVTLB_G1       = 5'd2;
  localparam logic [OP_W-1:0] INVTLB_G0       = 5'd3;
  localparam logic [OP_W-1:0] INVTLB_ASID     = 5'd4;
  localparam logic [OP_W-1:0] INVTLB_ASID_VA  = 5'd5;
  localparam logic [OP_W-1:0] INVTLB_GASID_VA = 5'd6;

  // One half of the even/odd page pair
  typedef struct packed {
    logic [PPN_W-1:0] ppn;
    logic [PLV_W-1:0] plv;
    logic [MAT_W-1:0] mat;
    logic             d;
    logic             v;
  } tlb_page_t;

  // VPPN compare: 4K pages use the full VPPN, 2M pages ignore VPPN[8:0], other sizes never hit
  function automatic logic vppn_hit(input logic [PS_W-1:0]   ps,
                                    input logic [VPPN_W-1:0] ent,
                                    input logic [VPPN_W-1:0] key);
    logic hit;
    hit = 1'b0;
    if (ps == PS_4K) begin
      hit = (ent == key);
    end else if (ps == PS_2M) begin
      hit = (ent[VPPN_W-1:9] == key[VPPN_W-1:9]);
    end
    return hit;
  endfunction

endpackage

// File: rtl/tlb_match.sv
// One combinational TLB search port: per-entry match, lowest-index priority pick, page select.
module tlb_match
  import tlb_pkg::*;
#(
  parameter  int unsigned N   = 16,
  localparam int unsigned IDX = $clog2(N)
) (
  input  logic [VPPN_W-1:0]         key_vppn,
  input  logic                      key_bit12,
  input  logic [ASID_W-1:0]         key_asid,
  input  logic [N-1:0]              ent_e,
  input  logic [N-1:0]              ent_g,
  input  logic [N-1:0][VPPN_W-1:0]  ent_vppn,
  input  logic [N-1:0][PS_W-1:0]    ent_ps,
  input  logic [N-1:0][ASID_W-1:0]  ent_asid,
  input  tlb_page_t [N-1:0]         ent_p0,
  input  tlb_page_t [N-1:0]         ent_p1,
  output logic [N-1:0]              match,
  output logic                      found,
  output logic [IDX-1:0]            index,
  output logic [PS_W-1:0]           ps,
  output tlb_page_t                 page
);

  logic odd;

  // Per-entry match: enabled, ASID or global, and VPPN compare at the entry's page size
  always_comb begin
    match = '0;
    for (int i = 0; i < int'(N); i++) begin
      match[i] = ent_e[i] && (ent_g[i] || (ent_asid[i] == key_asid)) &&
                 vppn_hit(ent_ps[i], ent_vppn[i], key_vppn);
    end
  end

  // Priority encoder; scanning downward leaves the lowest hitting index as the winner
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (match[i]) begin
        found = 1'b1;
        index = IDX'(i);
      end
    end
  end

  // Odd/even page select of the winning entry; everything zero on a miss
  always_comb begin
    ps   = '0;
    page = '0;
    odd  = 1'b0;
    if (found) begin
      ps   = ent_ps[index];
      odd  = (ent_ps[index] == PS_4K) ? key_bit12 : key_vppn[8];
      page = odd ? ent_p1[index] : ent_p0[index];
    end
  end

endmodule

// File: rtl/tlb.sv
// Fully-associative TLB: flop storage, write/read port, two search ports, INVTLB.
module tlb
  import tlb_pkg::*;
#(
  parameter  int unsigned TLBNUM = 16,
  localparam int unsigned IDX    = $clog2(TLBNUM)
) (
  input  logic              clk,
  input  logic              reset,
  // search port 0 (fetch)
  input  logic [VPPN_W-1:0] s0_vppn,
  input  logic              s0_va_bit12,
  input  logic [ASID_W-1:0] s0_asid,
  output logic              s0_found,
  output logic [IDX-1:0]    s0_index,
  output logic [PPN_W-1:0]  s0_ppn,
  output logic [PS_W-1:0]   s0_ps,
  output logic [PLV_W-1:0]  s0_plv,
  output logic [MAT_W-1:0]  s0_mat,
  output logic              s0_d,
  output logic              s0_v,
  // search port 1 (load/store, TLBSRCH, INVTLB key)
  input  logic [VPPN_W-1:0] s1_vppn,
  input  logic              s1_va_bit12,
  input  logic [ASID_W-1:0] s1_asid,
  output logic              s1_found,
  output logic [IDX-1:0]    s1_index,
  output logic [PPN_W-1:0]  s1_ppn,
  output logic [PS_W-1:0]   s1_ps,
  output logic [PLV_W-1:0]  s1_plv,
  output logic [MAT_W-1:0]  s1_mat,
  output logic              s1_d,
  output logic              s1_v,
  // invalidation
  input  logic              invtlb_valid,
  input  logic [OP_W-1:0]   invtlb_op,
  // write port
  input  logic              we,
  input  logic [IDX-1:0]    w_index,
  input  logic              w_e,
  input  logic [VPPN_W-1:0] w_vppn,
  input  logic [PS_W-1:0]   w_ps,
  input  logic [ASID_W-1:0] w_asid,
  input  logic              w_g,
  input  logic [PPN_W-1:0]  w_ppn0,
  input  logic [PLV_W-1:0]  w_plv0,
  input  logic [MAT_W-1:0]  w_mat0,
  input  logic              w_d0,
  input  logic              w_v0,
  input  logic [PPN_W-1:0]  w_ppn1,
  input  logic [PLV_W-1:0]  w_plv1,
  input  logic [MAT_W-1:0]  w_mat1,
  input  logic              w_d1,
  input  logic              w_v1,
  // read port
  input  logic [IDX-1:0]    r_index,
  output logic              r_e,
  output logic [VPPN_W-1:0] r_vppn,
  output logic [PS_W-1:0]   r_ps,
  output logic [ASID_W-1:0] r_asid,
  output logic              r_g,
  output logic [PPN_W-1:0]  r_ppn0,
  output logic [PLV_W-1:0]  r_plv0,
  output logic [MAT_W-1:0]  r_mat0,
  output logic              r_d0,
  output logic              r_v0,
  output logic [PPN_W-1:0]  r_ppn1,
  output logic [PLV_W-1:0]  r_plv1,
  output logic [MAT_W-1:0]  r_mat1,
  output logic              r_d1,
  output logic              r_v1
);

  logic [TLBNUM-1:0]              e_q, e_d;
  logic [TLBNUM-1:0]              g_q, g_d;
  logic [TLBNUM-1:0][VPPN_W-1:0]  vppn_q, vppn_d;
  logic [TLBNUM-1:0][PS_W-1:0]    ps_q, ps_d;
  logic [TLBNUM-1:0][ASID_W-1:0]  asid_q, asid_d;
  tlb_page_t [TLBNUM-1:0]         p0_q, p0_d;
  tlb_page_t [TLBNUM-1:0]         p1_q, p1_d;

  logic [TLBNUM-1:0] s0_match_unused;
  logic [TLBNUM-1:0] s1_match;
  logic [TLBNUM-1:0] asid_eq;
  logic [TLBNUM-1:0] inv_sel;
  tlb_page_t         s0_page, s1_page, w_p0, w_p1;

  assign w_p0 = '{ppn: w_ppn0, plv: w_plv0, mat: w_mat0, d: w_d0, v: w_v0};
  assign w_p1 = '{ppn: w_ppn1, plv: w_plv1, mat: w_mat1, d: w_d1, v: w_v1};

  tlb_match #(.N(TLBNUM)) u_s0 (
    .key_vppn  (s0_vppn),
    .key_bit12 (s0_va_bit12),
    .key_asid  (s0_asid),
    .ent_e     (e_q),
    .ent_g     (g_q),
    .ent_vppn  (vppn_q),
    .ent_ps    (ps_q),
    .ent_asid  (asid_q),
    .ent_p0    (p0_q),
    .ent_p1    (p1_q),
    .match     (s0_match_unused),
    .found     (s0_found),
    .index     (s0_index),
    .ps        (s0_ps),
    .page      (s0_page)
  );

  tlb_match #(.N(TLBNUM)) u_s1 (
    .key_vppn  (s1_vppn),
    .key_bit12 (s1_va_bit12),
    .key_asid  (s1_asid),
    .ent_e     (e_q),
    .ent_g     (g_q),
    .ent_vppn  (vppn_q),
    .ent_ps    (ps_q),
    .ent_asid  (asid_q),
    .ent_p0    (p0_q),
    .ent_p1    (p1_q),
    .match     (s1_match),
    .found     (s1_found),
    .index     (s1_index),
    .ps        (s1_ps),
    .page      (s1_page)
  );

  assign s0_ppn = s0_page.ppn;
  assign s0_plv = s0_page.plv;
  assign s0_mat = s0_page.mat;
  assign s0_d   = s0_page.d;
  assign s0_v   = s0_page.v;
  assign s1_ppn = s1_page.ppn;
  assign s1_plv = s1_page.plv;
  assign s1_mat = s1_page.mat;
  assign s1_d   = s1_page.d;
  assign s1_v   = s1_page.v;

  // Raw read mux, independent of E and of any matching
  assign r_e    = e_q[r_index];
  assign r_vppn = vppn_q[r_index];
  assign r_ps   = ps_q[r_index];
  assign r_asid = asid_q[r_index];
  assign r_g    = g_q[r_index];
  assign r_ppn0 = p0_q[r_index].ppn;
  assign r_plv0 = p0_q[r_index].plv;
  assign r_mat0 = p0_q[r_index].mat;
  assign r_d0   = p0_q[r_index].d;
  assign r_v0   = p0_q[r_index].v;
  assign r_ppn1 = p1_q[r_index].ppn;
  assign r_plv1 = p1_q[r_index].plv;
  assign r_mat1 = p1_q[r_index].mat;
  assign r_d1   = p1_q[r_index].d;
  assign r_v1   = p1_q[r_index].v;

  // Per-entry ASID equality against port 1's key, used by the ASID-qualified ops
  always_comb begin
    asid_eq = '0;
    for (int i = 0; i < int'(TLBNUM); i++) begin
      asid_eq[i] = (asid_q[i] == s1_asid);
    end
  end

  // Entries whose E bit this INVTLB clears; ops 5/6 reuse port 1's match (E=0 entries are moot)
  always_comb begin
    inv_sel = '0;
    if (invtlb_valid) begin
      case (invtlb_op)
        INVTLB_ALL0, INVTLB_ALL1: inv_sel = '1;
        INVTLB_G1:                inv_sel = g_q;
        INVTLB_G0:                inv_sel = ~g_q;
        INVTLB_ASID:              inv_sel = ~g_q & asid_eq;
        INVTLB_ASID_VA:           inv_sel = ~g_q & s1_match;
        INVTLB_GASID_VA:          inv_sel = s1_match;
        default:                  inv_sel = '0;
      endcase
    end
  end

  // Next-state: invalidation first, then a same-cycle write overrides its own entry
  always_comb begin
    e_d    = e_q & ~inv_sel;
    g_d    = g_q;
    vppn_d = vppn_q;
    ps_d   = ps_q;
    asid_d = asid_q;
    p0_d   = p0_q;
    p1_d   = p1_q;
    if (we) begin
      e_d[w_index]    = w_e;
      g_d[w_index]    = w_g;
      vppn_d[w_index] = w_vppn;
      ps_d[w_index]   = w_ps;
      asid_d[w_index] = w_asid;
      p0_d[w_index]   = w_p0;
      p1_d[w_index]   = w_p1;
    end
  end

  // Entry storage; reset clears every field asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q    <= '0;
      g_q    <= '0;
      vppn_q <= '0;
      ps_q   <= '0;
      asid_q <= '0;
      p0_q   <= '0;
      p1_q   <= '0;
    end else begin
      e_q    <= e_d;
      g_q    <= g_d;
      vppn_q <= vppn_d;
      ps_q   <= ps_d;
      asid_q <= asid_d;
      p0_q   <= p0_d;
      p1_q   <= p1_d;
    end
  end

endmodule

// File: tb/tb_tlb.sv
// Directed self-checking bench for the 16-entry TLB.
module tb_tlb;

  logic        clk;
  logic        reset;
  logic [18:0] s0_vppn, s1_vppn;
  logic        s0_va_bit12, s1_va_bit12;
  logic [9:0]  s0_asid, s1_asid;
  logic        s0_found, s1_found;
  logic [3:0]  s0_index, s1_index;
  logic [19:0] s0_ppn, s1_ppn;
  logic [5:0]  s0_ps, s1_ps;
  logic [1:0]  s0_plv, s1_plv, s0_mat, s1_mat;
  logic        s0_d, s1_d, s0_v, s1_v;
  logic        invtlb_valid;
  logic [4:0]  invtlb_op;
  logic        we;
  logic [3:0]  w_index, r_index;
  logic        w_e, w_g, w_d0, w_v0, w_d1, w_v1;
  logic [18:0] w_vppn;
  logic [5:0]  w_ps;
  logic [9:0]  w_asid;
  logic [19:0] w_ppn0, w_ppn1;
  logic [1:0]  w_plv0, w_mat0, w_plv1, w_mat1;
  logic        r_e, r_g, r_d0, r_v0, r_d1, r_v1;
  logic [18:0] r_vppn;
  logic [5:0]  r_ps;
  logic [9:0]  r_asid;
  logic [19:0] r_ppn0, r_ppn1;
  logic [1:0]  r_plv0, r_mat0, r_plv1, r_mat1;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [15:0] emask;

  tlb #(.TLBNUM(16)) dut (
    .clk(clk), .reset(reset),
    .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_ppn(s0_ppn), .s0_ps(s0_ps),
    .s0_plv(s0_plv), .s0_mat(s0_mat), .s0_d(s0_d), .s0_v(s0_v),
    .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_ppn(s1_ppn), .s1_ps(s1_ps),
    .s1_plv(s1_plv), .s1_mat(s1_mat), .s1_d(s1_d), .s1_v(s1_v),
    .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
    .we(we), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps),
    .w_asid(w_asid), .w_g(w_g),
    .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0), .w_d0(w_d0), .w_v0(w_v0),
    .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid), .r_g(r_g),
    .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0), .r_v0(r_v0),
    .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1), .r_v1(r_v1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load write-port fields; page attributes fixed so page selection is observable on plv/mat/d
  task automatic set_w(input logic [3:0] idx, input logic e, input logic [18:0] vppn,
                       input logic [5:0] ps, input logic [9:0] asid, input logic g,
                       input logic [19:0] ppn0, input logic [19:0] ppn1);
    w_index = idx; w_e = e; w_vppn = vppn; w_ps = ps; w_asid = asid; w_g = g;
    w_ppn0 = ppn0; w_plv0 = 2'd1; w_mat0 = 2'd1; w_d0 = 1'b1; w_v0 = 1'b1;
    w_ppn1 = ppn1; w_plv1 = 2'd3; w_mat1 = 2'd2; w_d1 = 1'b0; w_v1 = 1'b1;
  endtask

  task automatic wr(input logic [3:0] idx, input logic e, input logic [18:0] vppn,
                    input logic [5:0] ps, input logic [9:0] asid, input logic g,
                    input logic [19:0] ppn0, input logic [19:0] ppn1);
    set_w(idx, e, vppn, ps, asid, g, ppn0, ppn1);
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  // Entry i: 4K page, global when i%3==0, ASID 5 below index 8 else 6, VPPN 0x7000 when i%4==0
  task automatic fill_all();
    for (int i = 0; i < 16; i++) begin
      wr(4'(i), 1'b1, (i % 4 == 0) ? 19'h07000 : 19'(32'h100 + 32'(i)), 6'd12,
         (i < 8) ? 10'd5 : 10'd6, (i % 3 == 0), 20'(i), 20'(32'h100 + 32'(i)));
    end
  endtask

  task automatic inv(input logic [4:0] op);
    invtlb_valid = 1'b1;
    invtlb_op    = op;
    tick();
    invtlb_valid = 1'b0;
  endtask

  task automatic get_emask(output logic [15:0] m);
    m = '0;
    for (int i = 0; i < 16; i++) begin
      r_index = 4'(i);
      #1;
      m[i] = r_e;
    end
  endtask

  initial begin
    reset = 1'b0; we = 1'b0; invtlb_valid = 1'b0; invtlb_op = '0;
    s0_vppn = '0; s0_va_bit12 = 1'b0; s0_asid = '0;
    s1_vppn = '0; s1_va_bit12 = 1'b0; s1_asid = '0;
    r_index = 4'd5;
    set_w(4'd0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s0_found", 32'(s0_found), 32'd0);
    chk("rst_r_e", 32'(r_e), 32'd0);
    chk("rst_r_ppn0", 32'(r_ppn0), 32'd0);

    // Deassert reset; the very first edge carries the index-3 write
    reset = 1'b1;
    set_w(4'd3, 1'b1, 19'h00001, 6'd12, 10'd5, 1'b0, 20'h00111, 20'h00222);
    we = 1'b1;
    s0_vppn = 19'h00001; s0_va_bit12 = 1'b0; s0_asid = 10'd5;
    #1;
    chk("same_cycle_old", 32'(s0_found), 32'd0);
    tick();
    we = 1'b0;
    #1;
    chk("4k_found", 32'(s0_found), 32'd1);
    chk("4k_index", 32'(s0_index), 32'd3);
    chk("4k_ppn_even", 32'(s0_ppn), 32'h111);
    chk("4k_ps", 32'(s0_ps), 32'd12);
    chk("4k_plv_even", 32'(s0_plv), 32'd1);
    chk("4k_d_even", 32'(s0_d), 32'd1);
    s0_va_bit12 = 1'b1;
    #1;
    chk("4k_ppn_odd", 32'(s0_ppn), 32'h222);
    chk("4k_mat_odd", 32'(s0_mat), 32'd2);
    s0_asid = 10'd6;
    #1;
    chk("asid_miss_found", 32'(s0_found), 32'd0);
    chk("asid_miss_ppn", 32'(s0_ppn), 32'd0);

    // 2M global page at index 7; odd page chosen by VPPN[8]
    wr(4'd7, 1'b1, 19'h00A00, 6'd21, 10'd0, 1'b1, 20'h00333, 20'h00444);
    s1_vppn = 19'h00BFF; s1_asid = 10'h3FF; s1_va_bit12 = 1'b0;
    #1;
    chk("2m_found", 32'(s1_found), 32'd1);
    chk("2m_index", 32'(s1_index), 32'd7);
    chk("2m_ppn_odd", 32'(s1_ppn), 32'h444);
    chk("2m_ps", 32'(s1_ps), 32'd21);
    s1_vppn = 19'h00AFF;  // VPPN[8] clear -> even page
    #1;
    chk("2m_ppn_even", 32'(s1_ppn), 32'h333);

    // Duplicate hits: lowest index wins, then disabling it exposes the other
    wr(4'd2, 1'b1, 19'h12345, 6'd12, 10'd9, 1'b0, 20'hAAAAA, 20'h0);
    wr(4'd9, 1'b1, 19'h12345, 6'd12, 10'd9, 1'b0, 20'hBBBBB, 20'h0);
    s1_vppn = 19'h12345; s1_asid = 10'd9; s1_va_bit12 = 1'b0;
    #1;
    chk("dup_index", 32'(s1_index), 32'd2);
    chk("dup_ppn", 32'(s1_ppn), 32'hAAAAA);
    wr(4'd2, 1'b0, 19'h12345, 6'd12, 10'd9, 1'b0, 20'hAAAAA, 20'h0);
    #1;
    chk("dup_found_after", 32'(s1_found), 32'd1);
    chk("dup_index_after", 32'(s1_index), 32'd9);
    chk("dup_ppn_after", 32'(s1_ppn), 32'hBBBBB);

    // INVTLB ops on a freshly filled table, key ASID 5 / VPPN 0x7000
    s1_vppn = 19'h07000; s1_asid = 10'd5;
    fill_all(); get_emask(emask);
    chk("fill_all", 32'(emask), 32'hFFFF);
    inv(5'd2); get_emask(emask);
    chk("inv_op2", 32'(emask), 32'h6DB6);
    fill_all(); inv(5'd3); get_emask(emask);
    chk("inv_op3", 32'(emask), 32'h9249);
    fill_all(); inv(5'd4); get_emask(emask);
    chk("inv_op4", 32'(emask), 32'hFF49);
    fill_all(); inv(5'd5); get_emask(emask);
    chk("inv_op5", 32'(emask), 32'hFFEF);
    r_index = 4'd4;
    #1;
    chk("inv_raw_vppn_kept", 32'(r_vppn), 32'h07000);
    fill_all(); inv(5'd6); get_emask(emask);
    chk("inv_op6", 32'(emask), 32'hEFEE);
    fill_all(); inv(5'd7); get_emask(emask);
    chk("inv_op7", 32'(emask), 32'hFFFF);
    inv(5'd31); get_emask(emask);
    chk("inv_op31", 32'(emask), 32'hFFFF);

    // Write and invalidate-all in the same cycle: only the written entry survives
    set_w(4'd4, 1'b1, 19'h07000, 6'd12, 10'd5, 1'b0, 20'h44444, 20'h0);
    we = 1'b1; invtlb_valid = 1'b1; invtlb_op = 5'd0;
    tick();
    we = 1'b0; invtlb_valid = 1'b0;
    get_emask(emask);
    chk("we_plus_inv", 32'(emask), 32'h0010);

    // Mid-stream reset drops every hit and E bit before the next edge
    s0_vppn = 19'h07000; s0_asid = 10'd5; s0_va_bit12 = 1'b0;
    r_index = 4'd4;
    tick();
    chk("pre_rst_s0_index", 32'(s0_index), 32'd4);
    chk("pre_rst_s1_found", 32'(s1_found), 32'd1);
    chk("pre_rst_r_e", 32'(r_e), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_s0_found", 32'(s0_found), 32'd0);
    chk("mid_rst_s1_found", 32'(s1_found), 32'd0);
    chk("mid_rst_r_e", 32'(r_e), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_r_vppn", 32'(r_vppn), 32'd0);
    chk("post_rst_s0_found", 32'(s0_found), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
